// File: rtl/pwm_ramp_scheduler.sv
// pwm_ramp_scheduler
//   Holds the frequency and duty counts of one PWM channel. Firmware writes a
//   target duty over SPI; the duty then moves toward it in fixed steps, one
//   step every `div` PWM periods. Steps land only on period boundaries, so the
//   PWM core never sees a glitched period.
//
// Handshake: a command is taken in any cycle with spi_data_valid_r=1 and
//   spi_addr_r==DEV_ID. There is no back-pressure: every qualified command
//   is consumed in the cycle it is presented, and its effect is visible on
//   the outputs the next cycle.
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   spi_cmd_r          decoded SPI command code
//   spi_addr_r         decoded SPI address (compared against DEV_ID)
//   spi_data_r         decoded SPI payload (low bits used)
//   spi_data_valid_r   one-cycle qualifier for cmd/addr/data
//   pwm_period_end     one-cycle pulse from the PWM core at each period wrap
//   pwm_freq           period count to the PWM core
//   pwm_duty           duty count to the PWM core (never exceeds pwm_freq)
//   duty_update        pulse in the cycle pwm_duty takes a new value
//   busy               high while ramping (this is the FSM state: IDLE=0, RAMP=1)
//   done               pulse when pwm_duty reaches the target

`ifndef C_SET_PWM_FREQ
`define C_SET_PWM_FREQ        16'h0010
`endif
`ifndef C_SET_PWM_RAMP_STEP
`define C_SET_PWM_RAMP_STEP   16'h0011
`endif
`ifndef C_SET_PWM_RAMP_DIV
`define C_SET_PWM_RAMP_DIV    16'h0012
`endif
`ifndef C_SET_PWM_RAMP_TARGET
`define C_SET_PWM_RAMP_TARGET 16'h0013
`endif
`ifndef C_PWM_RAMP_ABORT
`define C_PWM_RAMP_ABORT      16'h0014
`endif

module pwm_ramp_scheduler #(
    parameter logic [7:0] DEV_ID         = 8'd0,
    parameter int          PWM_CNTR_WIDTH = 12,
    parameter int          DIV_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [15:0]               spi_cmd_r,
    input  logic [7:0]                spi_addr_r,
    input  logic [39:0]               spi_data_r,
    input  logic                      spi_data_valid_r,
    input  logic                      pwm_period_end,
    output logic [PWM_CNTR_WIDTH-1:0] pwm_freq,
    output logic [PWM_CNTR_WIDTH-1:0] pwm_duty,
    output logic                      duty_update,
    output logic                      busy,
    output logic                      done
);

    localparam int W = PWM_CNTR_WIDTH;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RAMP = 1'b1;

    logic [0:0]           state;
    logic [W-1:0]         target;
    logic [W-1:0]         step;
    logic [DIV_WIDTH-1:0] div;
    logic [DIV_WIDTH-1:0] div_cnt;

    logic                 accept;
    logic [W-1:0]         data;
    logic [W-1:0]         clamped;
    logic                 dir_up;
    logic [W-1:0]         diff;
    logic [DIV_WIDTH-1:0] div_last;
    logic                 unused_data_bits;

    assign accept  = spi_data_valid_r && (spi_addr_r == DEV_ID);
    assign data    = spi_data_r[W-1:0];
    assign clamped = (data > pwm_freq) ? pwm_freq : data;

    // Distance to target computed with explicit direction so neither the
    // subtraction nor the following step can wrap.
    assign dir_up  = (target > pwm_duty);
    assign diff    = dir_up ? (target - pwm_duty) : (pwm_duty - target);

    // div==0 behaves as div==1: a step on every period end.
    assign div_last = (div == '0) ? '0 : (div - 1'b1);

    assign busy = (state == RAMP);

    assign unused_data_bits = ^spi_data_r;

    always_ff @(posedge clk) begin
        duty_update <= 1'b0;
        done        <= 1'b0;
        if (reset) begin
            state    <= IDLE;
            pwm_freq <= '0;
            pwm_duty <= '0;
            target   <= '0;
            step     <= '0;
            div      <= '0;
            div_cnt  <= '0;
        end else if (accept) begin
            // Any accepted write swallows a coincident period_end.
            case (spi_cmd_r)
                `C_PWM_RAMP_ABORT: begin
                    state   <= IDLE;
                    div_cnt <= '0;
                end
                `C_SET_PWM_RAMP_TARGET: begin
                    target  <= clamped;
                    div_cnt <= '0;
                    if ((step == '0) || (clamped == pwm_duty)) begin
                        pwm_duty    <= clamped;
                        duty_update <= (clamped != pwm_duty);
                        done        <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        state <= RAMP;
                    end
                end
                `C_SET_PWM_FREQ: begin
                    pwm_freq <= data;
                    if (pwm_duty > data) begin
                        pwm_duty    <= data;
                        duty_update <= 1'b1;
                    end
                    if (target > data) begin
                        target <= data;
                    end
                end
                `C_SET_PWM_RAMP_STEP: step <= data;
                `C_SET_PWM_RAMP_DIV:  div  <= spi_data_r[DIV_WIDTH-1:0];
                default: ;
            endcase
        end else if ((state == RAMP) && pwm_period_end) begin
            if (div_cnt >= div_last) begin
                div_cnt     <= '0;
                duty_update <= 1'b1;
                if (diff <= step) begin
                    pwm_duty <= target;
                    done     <= 1'b1;
                    state    <= IDLE;
                end else if (dir_up) begin
                    pwm_duty <= pwm_duty + step;
                end else begin
                    pwm_duty <= pwm_duty - step;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// Bench for pwm_ramp_scheduler: a table of per-cycle stimulus records with
// expected outputs, followed by hand-written multi-cycle corner sequences.
// Every driven cycle pushes its expected output word onto exp_q; the word is
// popped and compared one clock later, away from the active edge.
module tb_pwm_ramp_scheduler;

    localparam logic [15:0] C_FREQ   = 16'h0010;
    localparam logic [15:0] C_STEP   = 16'h0011;
    localparam logic [15:0] C_DIV    = 16'h0012;
    localparam logic [15:0] C_TARGET = 16'h0013;
    localparam logic [15:0] C_ABORT  = 16'h0014;
    localparam logic [15:0] C_NONE   = 16'h0000;
    localparam logic [7:0]  ID       = 8'd0;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] spi_cmd_r;
    logic [7:0]  spi_addr_r;
    logic [39:0] spi_data_r;
    logic        spi_data_valid_r;
    logic        pwm_period_end;
    logic [11:0] pwm_freq;
    logic [11:0] pwm_duty;
    logic        duty_update;
    logic        busy;
    logic        done;

    int tests_run = 0;
    int tests_failed = 0;

    // {freq, duty, busy, done, duty_update}
    logic [26:0] exp_q[$];

    typedef struct {
        logic        rst;
        logic        v;
        logic [15:0] cmd;
        logic [7:0]  addr;
        logic [11:0] data;
        logic        pe;
        logic [11:0] ef;
        logic [11:0] ed;
        logic        eb;
        logic        edn;
        logic        eu;
        string       name;
    } vec_t;

    vec_t vecs[$];

    pwm_ramp_scheduler #(.DEV_ID(8'd0), .PWM_CNTR_WIDTH(12), .DIV_WIDTH(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .spi_cmd_r        (spi_cmd_r),
        .spi_addr_r       (spi_addr_r),
        .spi_data_r       (spi_data_r),
        .spi_data_valid_r (spi_data_valid_r),
        .pwm_period_end   (pwm_period_end),
        .pwm_freq         (pwm_freq),
        .pwm_duty         (pwm_duty),
        .duty_update      (duty_update),
        .busy             (busy),
        .done             (done)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Driver: present one cycle of stimulus and record what must come out.
    task automatic drive(input logic rst, input logic v, input logic [15:0] cmd,
                         input logic [7:0] addr, input logic [11:0] data, input logic pe,
                         input logic [11:0] ef, input logic [11:0] ed,
                         input logic eb, input logic edn, input logic eu, input string name);
        logic [26:0] exp_w;
        logic [26:0] act_w;
        logic [23:0] junk;
        @(negedge clk);
        junk             = 24'($urandom_range(0, 32'hFFFFFF));
        reset            = rst;
        spi_data_valid_r = v;
        spi_cmd_r        = cmd;
        spi_addr_r       = addr;
        // Bits above the payload are noise the DUT must ignore.
        spi_data_r       = {junk, 4'h0, data};
        pwm_period_end   = pe;
        exp_q.push_back({ef, ed, eb, edn, eu});
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    // Scoreboard: pop the oldest expectation and compare.
    task automatic check_out(input string name);
        logic [26:0] exp_w;
        logic [26:0] act_w;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        exp_w = exp_q.pop_front();
        act_w = {pwm_freq, pwm_duty, busy, done, duty_update};
        tests_run++;
        if (act_w !== exp_w) begin
            tests_failed++;
            $display("FAIL %s: got freq=%0d duty=%0d busy=%b done=%b upd=%b, expected freq=%0d duty=%0d busy=%b done=%b upd=%b",
                     name, act_w[26:15], act_w[14:3], act_w[2], act_w[1], act_w[0],
                     exp_w[26:15], exp_w[14:3], exp_w[2], exp_w[1], exp_w[0]);
        end
    endtask

    function automatic void add(input logic rst, input logic v, input logic [15:0] cmd,
                                input logic [7:0] addr, input logic [11:0] data, input logic pe,
                                input logic [11:0] ef, input logic [11:0] ed,
                                input logic eb, input logic edn, input logic eu, input string name);
        vec_t r;
        r.rst = rst; r.v = v; r.cmd = cmd; r.addr = addr; r.data = data; r.pe = pe;
        r.ef = ef; r.ed = ed; r.eb = eb; r.edn = edn; r.eu = eu; r.name = name;
        vecs.push_back(r);
    endfunction

    initial begin
        logic [11:0] d;
        logic [7:0]  bad_addr;

        reset = 1'b1; spi_cmd_r = '0; spi_addr_r = '0; spi_data_r = '0;
        spi_data_valid_r = 1'b0; pwm_period_end = 1'b0;

        // ---------------- table ----------------
        add(1, 0, C_NONE,   ID, 0,   0, 0,   0, 0, 0, 0, "reset");
        // Ramp up 0 -> 50, step 10, div 2
        add(0, 1, C_FREQ,   ID, 100, 0, 100, 0, 0, 0, 0, "up_freq");
        add(0, 1, C_STEP,   ID, 10,  0, 100, 0, 0, 0, 0, "up_step");
        add(0, 1, C_DIV,    ID, 2,   0, 100, 0, 0, 0, 0, "up_div");
        add(0, 1, C_TARGET, ID, 50,  0, 100, 0, 1, 0, 0, "up_target");
        d = 0;
        for (int i = 0; i < 5; i++) begin
            add(0, 0, C_NONE, ID, 0, 1, 100, d, 1, 0, 0, "up_pe_hold");
            d = d + 12'd10;
            add(0, 0, C_NONE, ID, 0, 1, 100, d, (i != 4), (i == 4), 1, "up_pe_step");
        end
        add(0, 0, C_NONE,   ID, 0,   0, 100, 50, 0, 0, 0, "up_after");
        // Ramp down 50 -> 5, div 1
        add(0, 1, C_DIV,    ID, 1,   0, 100, 50, 0, 0, 0, "dn_div");
        add(0, 1, C_TARGET, ID, 5,   0, 100, 50, 1, 0, 0, "dn_target");
        add(0, 0, C_NONE,   ID, 0,   1, 100, 40, 1, 0, 1, "dn_40");
        add(0, 0, C_NONE,   ID, 0,   1, 100, 30, 1, 0, 1, "dn_30");
        add(0, 0, C_NONE,   ID, 0,   1, 100, 20, 1, 0, 1, "dn_20");
        add(0, 0, C_NONE,   ID, 0,   1, 100, 10, 1, 0, 1, "dn_10");
        add(0, 0, C_NONE,   ID, 0,   1, 100, 5,  0, 1, 1, "dn_5_done");
        add(0, 0, C_NONE,   ID, 0,   1, 100, 5,  0, 0, 0, "idle_pe_ignored");
        // step==0 jump
        add(0, 1, C_STEP,   ID, 0,   0, 100, 5,  0, 0, 0, "jump_step0");
        add(0, 1, C_TARGET, ID, 70,  0, 100, 70, 0, 1, 1, "jump_target70");
        // freq clamps duty
        add(0, 1, C_FREQ,   ID, 30,  0, 30,  30, 0, 0, 1, "freq_clamp_duty");
        add(0, 1, C_FREQ,   ID, 100, 0, 100, 30, 0, 0, 0, "freq_restore");
        // target above freq ramps to freq
        add(0, 1, C_STEP,   ID, 10,  0, 100, 30, 0, 0, 0, "clamp_step");
        add(0, 1, C_TARGET, ID, 200, 0, 100, 30, 1, 0, 0, "clamp_target200");
        d = 30;
        for (int i = 0; i < 7; i++) begin
            d = d + 12'd10;
            add(0, 0, C_NONE, ID, 0, 1, 100, d, (i != 6), (i == 6), 1, "clamp_step_pe");
        end

        foreach (vecs[i])
            drive(vecs[i].rst, vecs[i].v, vecs[i].cmd, vecs[i].addr, vecs[i].data, vecs[i].pe,
                  vecs[i].ef, vecs[i].ed, vecs[i].eb, vecs[i].edn, vecs[i].eu, vecs[i].name);

        // ---------------- hand-written sequences ----------------
        // Foreign address writes change nothing.
        bad_addr = 8'($urandom_range(1, 255));
        drive(0, 1, C_FREQ,   bad_addr, 7,  0, 100, 100, 0, 0, 0, "addr_mismatch_freq");
        drive(0, 1, C_TARGET, bad_addr, 3,  0, 100, 100, 0, 0, 0, "addr_mismatch_target");
        drive(0, 1, 16'h00FF, ID,       3,  1, 100, 100, 0, 0, 0, "unknown_cmd");

        // Retarget mid-ramp: heading to 80, at 30, retarget to 20.
        drive(0, 1, C_STEP,   ID, 0,  0, 100, 100, 0, 0, 0, "rt_step0");
        drive(0, 1, C_TARGET, ID, 0,  0, 100, 0,   0, 1, 1, "rt_jump0");
        drive(0, 1, C_STEP,   ID, 10, 0, 100, 0,   0, 0, 0, "rt_step10");
        drive(0, 1, C_TARGET, ID, 80, 0, 100, 0,   1, 0, 0, "rt_target80");
        drive(0, 0, C_NONE,   ID, 0,  1, 100, 10,  1, 0, 1, "rt_10");
        drive(0, 0, C_NONE,   ID, 0,  1, 100, 20,  1, 0, 1, "rt_20");
        drive(0, 0, C_NONE,   ID, 0,  1, 100, 30,  1, 0, 1, "rt_30");
        // Coincident period_end is swallowed by the write.
        drive(0, 1, C_TARGET, ID, 20, 1, 100, 30,  1, 0, 0, "rt_retarget20");
        drive(0, 0, C_NONE,   ID, 0,  1, 100, 20,  0, 1, 1, "rt_20_done");

        // Abort at 40, with a coincident period_end.
        drive(0, 1, C_TARGET, ID, 80, 0, 100, 20,  1, 0, 0, "ab_target80");
        drive(0, 0, C_NONE,   ID, 0,  1, 100, 30,  1, 0, 1, "ab_30");
        drive(0, 0, C_NONE,   ID, 0,  1, 100, 40,  1, 0, 1, "ab_40");
        drive(0, 1, C_ABORT,  ID, 0,  1, 100, 40,  0, 0, 0, "ab_abort_pe");
        drive(0, 0, C_NONE,   ID, 0,  1, 100, 40,  0, 0, 0, "ab_hold");

        // div=0 behaves as 1, then reset mid-ramp.
        drive(0, 1, C_DIV,    ID, 0,  0, 100, 40,  0, 0, 0, "div0");
        drive(0, 1, C_TARGET, ID, 90, 0, 100, 40,  1, 0, 0, "rst_target90");
        drive(0, 0, C_NONE,   ID, 0,  1, 100, 50,  1, 0, 1, "rst_50");
        drive(1, 0, C_NONE,   ID, 0,  1, 0,   0,   0, 0, 0, "rst_mid_ramp");
        drive(0, 0, C_NONE,   ID, 0,  1, 0,   0,   0, 0, 0, "rst_after");

        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
